instr_encoder: RTL and testbench

- Inverse of the core's control decoder. Accepts decoded instruction fields over a valid/ready request port and encodes each into a 32-bit RV32I word.
- Encoded words are buffered in a small FIFO and written sequentially into the instruction memory write port at an auto-incrementing word address.
- Used by the self-test/program-loader path to build instruction streams in hardware. Also serves as the golden encoder paired with the decoder in regression benches.

---
 rtl/encoder_pkg.sv | 59 +++++
 rtl/enc_fifo.sv | 63 ++++++
 rtl/instr_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// RV32I encoder shared definitions: request kinds, opcodes, funct3/funct7 values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Shared with the control decoder so both sides agree on opcode and field values.
package encoder_pkg;

  // Request kind as presented on req_kind; codes 9..15 are illegal.
  typedef enum logic [3:0] {
    KIND_R      = 4'd0,
    KIND_I      = 4'd1,
    KIND_LOAD   = 4'd2,
    KIND_STORE  = 4'd3,
    KIND_BRANCH = 4'd4,
    KIND_LUI    = 4'd5,
    KIND_AUIPC  = 4'd6,
    KIND_JAL    = 4'd7,
    KIND_JALR   = 4'd8
  } kind_e;

  // Sequencer states of the encoder.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  // funct3 values that carry special meaning for encoding/legality.
  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_JALR    = 3'd0;
  localparam logic [2:0] F3_LD      = 3'd3;  // no 64-bit load in RV32I
  localparam logic [2:0] F3_ST_MAX  = 3'd2;  // SB/SH/SW only
  localparam logic [2:0] F3_BR_RSV2 = 3'd2;
  localparam logic [2:0] F3_BR_RSV3 = 3'd3;

  // funct7 values for R-type / shift-immediate.
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Shift funct3 values take a shamt rather than a 12-bit immediate.
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Generic synchronous FIFO with showahead head (head valid whenever !empty).
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
//
// Ports: clk, rst (async active-high), push/push_dat, pop, head_dat, full, empty.
module enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // When full, a simultaneous pop frees the slot being written, so the push is honoured.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes decoded RV32I fields into instruction words and streams them to instruction memory.
// Latency: word accepted at cycle N can be written at cycle N+1 at the earliest.
// Backpressure: req_ready drops while the buffer is full; imem_we/addr/din hold until imem_ready.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready, req_*     decoded-field request (kind, func3, alt, rd, rs1, rs2, imm)
//   start, start_addr              begin a run at start_addr (IDLE only)
//   flush                          stop accepting and drain (RUN only)
//   imem_we/addr/din, imem_ready   instruction memory write port
//   done, err, words_written       drain-complete pulse, sticky illegal flag, write count
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [2:0]        req_func3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              flush,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  input  logic              imem_ready,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  state_e            state;
  state_e            state_nxt;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              req_accept;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_head;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_ptr;
  logic              start_go;

  // Immediate bits above bit 20 never land in any instruction format.
  logic unused_imm_hi;
  assign unused_imm_hi = ^req_imm[31:21];

  // ---------------------------------------------------------------------------
  // Field encoder: pure function of the request fields.
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (req_kind)
      KIND_R: begin
        enc_word    = {(req_alt ? F7_ALT : F7_BASE), req_rs2, req_rs1, req_func3, req_rd, OP_R};
        // Only SUB and SRA have an alternate form.
        enc_illegal = req_alt && (req_func3 != F3_ADD_SUB) && (req_func3 != F3_SR);
      end
      KIND_I: begin
        if (is_shift(req_func3)) begin
          // Shift immediates carry shamt in imm[4:0] and the SRAI select in imm[10].
          enc_word    = {1'b0, req_alt, 5'b0, req_imm[4:0], req_rs1, req_func3, req_rd, OP_I};
          enc_illegal = req_alt && (req_func3 == F3_SLL);
        end else begin
          enc_word = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_I};
        end
      end
      KIND_LOAD: begin
        enc_word    = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_LOAD};
        enc_illegal = (req_func3 == F3_LD) || (req_func3[2:1] == 2'b11);
      end
      KIND_STORE: begin
        enc_word    = {req_imm[11:5], req_rs2, req_rs1, req_func3, req_imm[4:0], OP_STORE};
        enc_illegal = (req_func3 > F3_ST_MAX);
      end
      KIND_BRANCH: begin
        enc_word    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_func3,
                       req_imm[4:1], req_imm[11], OP_BRANCH};
        // Branch targets are halfword aligned; an odd offset cannot be represented.
        enc_illegal = (req_func3 == F3_BR_RSV2) || (req_func3 == F3_BR_RSV3) || req_imm[0];
      end
      KIND_LUI: begin
        enc_word = {req_imm[19:0], req_rd, OP_LUI};
      end
      KIND_AUIPC: begin
        enc_word = {req_imm[19:0], req_rd, OP_AUIPC};
      end
      KIND_JAL: begin
        enc_word    = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
        enc_illegal = req_imm[0];
      end
      KIND_JALR: begin
        enc_word    = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_JALR};
        enc_illegal = (req_func3 != F3_JALR);
      end
      default: begin
        enc_illegal = 1'b1;
      end
    endcase
  end

  // Illegal requests are consumed (handshake completes) but never buffered.
  assign req_accept = req_valid && req_ready;
  assign fifo_push  = req_accept && !enc_illegal;
  assign wr_fire    = imem_we && imem_ready;
  assign start_go   = (state == ST_IDLE) && start;

  enc_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (enc_word),
    .pop      (wr_fire),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Sequencer: state register / next state / outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      // In DRAIN the write strobe is exactly !fifo_empty, so empty also means no write pending.
      ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_RUN: begin
        // Deliberately ignores a same-cycle pop when full.
        req_ready = !fifo_full;
        imem_we   = !fifo_empty;
      end
      ST_DRAIN: imem_we = !fifo_empty;
      ST_DONE:  done    = 1'b1;
      default:  ;
    endcase
  end

  // Head of the buffer drives the write data directly, so it holds until popped.
  assign imem_din  = fifo_head;
  assign imem_addr = wr_ptr;

  // ---------------------------------------------------------------------------
  // Write pointer, write counter and sticky error.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      words_written <= '0;
      err           <= 1'b0;
    end else begin
      if (start_go) begin
        wr_ptr        <= start_addr;
        words_written <= '0;
        err           <= 1'b0;
      end else begin
        if (wr_fire) begin
          // Wraps silently at the top of the address space.
          wr_ptr        <= wr_ptr + 1'b1;
          words_written <= words_written + 1'b1;
        end
        if (req_accept && enc_illegal) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized requests
// checked against a field-placement reference model and an expected-write queue.
// Outputs are sampled on the falling clock edge; inputs change 1 time unit after the rising edge.
module tb_instr_encoder;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_kind = '0;
  logic [2:0]        req_func3 = '0;
  logic              req_alt = 1'b0;
  logic [4:0]        req_rd = '0;
  logic [4:0]        req_rs1 = '0;
  logic [4:0]        req_rs2 = '0;
  logic [31:0]       req_imm = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              flush = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              imem_ready = 1'b0;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_written;

  int errors = 0;
  int checks = 0;

  // Reference state: expected writes as {addr, word}, next address, counters.
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W-1:0]  next_addr = '0;
  int                 exp_ww = 0;
  logic               model_err = 1'b0;
  int                 done_cnt = 0;

  bit                 rnd_en = 1'b0;
  logic               ready_force = 1'b1;

  logic               hold_vld = 1'b0;
  logic [ADDR_W-1:0]  hold_addr = '0;
  logic [31:0]        hold_din = '0;

  instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_func3     (req_func3),
    .req_alt       (req_alt),
    .req_rd        (req_rd),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_imm       (req_imm),
    .start         (start),
    .start_addr    (start_addr),
    .flush         (flush),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_din      (imem_din),
    .imem_ready    (imem_ready),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instruction word built by placing each field at its architectural bit position.
  function automatic logic [31:0] ref_word(input logic [3:0] k, input logic [2:0] f3,
                                           input logic alt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
    logic [31:0] rdf, mid, rs2f, i12, alt30;
    rdf   = 32'(rd) << 7;
    mid   = (32'(f3) << 12) | (32'(rs1) << 15);
    rs2f  = 32'(rs2) << 20;
    i12   = (imm & 32'hFFF) << 20;
    alt30 = alt ? 32'h4000_0000 : 32'h0;
    case (k)
      4'd0: return 32'h33 | rdf | mid | rs2f | alt30;
      4'd1: if (f3 == 3'd1 || f3 == 3'd5) return 32'h13 | rdf | mid | ((imm & 32'h1F) << 20) | alt30;
            else return 32'h13 | rdf | mid | i12;
      4'd2: return 32'h03 | rdf | mid | i12;
      4'd3: return 32'h23 | ((imm & 32'h1F) << 7) | mid | rs2f | (((imm >> 5) & 32'h7F) << 25);
      4'd4: return 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) | mid | rs2f
                   | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      4'd5: return 32'h37 | rdf | ((imm & 32'hFFFFF) << 12);
      4'd6: return 32'h17 | rdf | ((imm & 32'hFFFFF) << 12);
      4'd7: return 32'h6F | rdf | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                   | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      4'd8: return 32'h67 | rdf | mid | i12;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] k, input logic [2:0] f3,
                                   input logic alt, input logic [31:0] imm);
    case (k)
      4'd0: return !(alt && f3 != 3'd0 && f3 != 3'd5);
      4'd1: return !(alt && f3 == 3'd1);
      4'd2: return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      4'd3: return f3 <= 3'd2;
      4'd4: return !(f3 == 3'd2 || f3 == 3'd3 || imm[0]);
      4'd5, 4'd6: return 1'b1;
      4'd7: return !imm[0];
      4'd8: return f3 == 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  // imem_ready source: forced level or random stalls.
  initial forever begin
    @(posedge clk);
    #2;
    imem_ready = rnd_en ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Write monitor: scoreboard every accepted write, check hold stability, count done pulses.
  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("we_held", {63'b0, imem_we}, 64'd1);
        check("addr_held", {50'b0, imem_addr}, {50'b0, hold_addr});
        check("din_held", {32'b0, imem_din}, {32'b0, hold_din});
      end
      hold_vld  = imem_we && !imem_ready;
      hold_addr = imem_addr;
      hold_din  = imem_din;
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {63'b0, imem_we}, 64'd0);
        end else begin
          logic [ADDR_W+31:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {50'b0, imem_addr}, {50'b0, e[ADDR_W+31:32]});
          check("wr_data", {32'b0, imem_din}, {32'b0, e[31:0]});
        end
      end
      if (done) done_cnt++;
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic begin_run(input logic [ADDR_W-1:0] a);
    start_addr = a;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    next_addr  = a;
    exp_ww     = 0;
    model_err  = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("err_after_start", {63'b0, err}, 64'd0);
    check("ww_after_start", {49'b0, words_written}, 64'd0);
    check("ready_in_run", {63'b0, req_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_req(input logic [3:0] k, input logic [2:0] f3, input logic alt,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input bit use_lit, input logic [31:0] lit,
                          input bit with_flush);
    bit acc;
    int n;
    req_kind  = k;   req_func3 = f3;  req_alt = alt;
    req_rd    = rd;  req_rs1   = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    flush     = with_flush;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    check("req_accepted", {63'b0, acc}, 64'd1);
    if (acc) begin
      if (ref_legal(k, f3, alt, imm)) begin
        exp_q.push_back({next_addr, use_lit ? lit : ref_word(k, f3, alt, rd, rs1, rs2, imm)});
        next_addr = next_addr + 1'b1;
        exp_ww++;
      end else begin
        model_err = 1'b1;
      end
    end
  endtask

  task automatic end_run(input bit do_flush);
    int n;
    done_cnt = 0;
    if (do_flush) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("all_written", 64'(exp_q.size()), 64'd0);
    check("words_written", {49'b0, words_written}, 64'(exp_ww));
    check("err_flag", {63'b0, err}, {63'b0, model_err});
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {63'b0, req_ready}, 64'd0);
    check("rst_we", {63'b0, imem_we}, 64'd0);
    check("rst_addr", {50'b0, imem_addr}, 64'd0);
    check("rst_din", {32'b0, imem_din}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    check("rst_ww", {49'b0, words_written}, 64'd0);
    @(posedge clk); #1;

    // R add / sub.
    ready_force = 1'b1;
    begin_run(14'h10);
    send_req(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0);
    send_req(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, 1'b0);
    end_run(1'b1);

    // addi / lw / sw, then beq / jal / lui.
    begin_run(14'h40);
    send_req(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,  1'b1, 32'h00500093, 1'b0);
    send_req(4'd2, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8,  1'b1, 32'h00812283, 1'b0);
    send_req(4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd12, 1'b1, 32'h00512623, 1'b0);
    send_req(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,  1'b1, 32'h00208463, 1'b0);
    send_req(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 32'h010000EF, 1'b0);
    send_req(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345, 1'b1, 32'h123452B7, 1'b0);
    end_run(1'b1);

    // Illegal requests: consumed, nothing written, err sticky until next start.
    begin_run(14'h80);
    send_req(4'd2, 3'd7, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    send_req(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("illegal_err", {63'b0, err}, 64'd1);
    check("illegal_no_we", {63'b0, imem_we}, 64'd0);
    @(posedge clk); #1;
    end_run(1'b1);

    // Backpressure: four accepts fill the buffer, outputs hold on the first word.
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    begin_run(14'h100);
    for (int i = 0; i < 4; i++) begin
      send_req(4'd1, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 7), 1'b0, 32'd0, 1'b0);
    end
    @(negedge clk);
    check("full_ready_low", {63'b0, req_ready}, 64'd0);
    check("stall_we", {63'b0, imem_we}, 64'd1);
    check("stall_addr", {50'b0, imem_addr}, 64'h100);
    check("stall_din", {32'b0, imem_din}, {32'b0, exp_q[0][31:0]});
    repeat (3) @(posedge clk);
    #1;
    ready_force = 1'b1;
    send_req(4'd6, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'hABCDE, 1'b0, 32'd0, 1'b0);
    end_run(1'b1);

    // Address wrap with flush in the accept cycle of the last request.
    begin_run(14'h3FFF);
    send_req(4'd8, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h7F0, 1'b0, 32'd0, 1'b0);
    send_req(4'd1, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3,   1'b0, 32'd0, 1'b1);
    end_run(1'b0);

    // Randomized requests with random memory stalls.
    begin_run(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)));
    rnd_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  k;
      logic [2:0]  f3;
      logic        alt;
      logic [31:0] imm;
      k   = 4'($urandom_range(0, 9));
      if (k == 4'd9) k = 4'($urandom_range(9, 15));
      f3  = 3'($urandom_range(0, 7));
      alt = 1'b0;
      if (k == 4'd0 || (k == 4'd1 && (f3 == 3'd1 || f3 == 3'd5))) alt = 1'($urandom_range(0, 1));
      imm = $urandom;
      if ((k == 4'd4 || k == 4'd7) && $urandom_range(0, 7) != 0) imm[0] = 1'b0;
      send_req(k, f3, alt, 5'($urandom), 5'($urandom), 5'($urandom), imm, 1'b0, 32'd0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    rnd_en = 1'b0;
    end_run(1'b1);

    // Reset in the middle of a stalled stream.
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    begin_run(14'h20);
    send_req(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1, 1'b0, 32'd0, 1'b0);
    send_req(4'd5, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h2, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_we", {63'b0, imem_we}, 64'd0);
    check("midrst_ready", {63'b0, req_ready}, 64'd0);
    check("midrst_addr", {50'b0, imem_addr}, 64'd0);
    check("midrst_ww", {49'b0, words_written}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ready_force = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("postrst_we", {63'b0, imem_we}, 64'd0);
    check("postrst_idle_ready", {63'b0, req_ready}, 64'd0);
    check("postrst_done", {63'b0, done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
